// File: rtl/multicycle_mainfsm_if.sv
// Control bundle between the main sequencing FSM and the rest of the
// multicycle controller: decoded instruction fields and multiplier status
// in, datapath selects/strobes and debug state out.
interface multicycle_mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       MulDone;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       MulStart;
    logic       MulErr;
    logic [3:0] State;

    // FSM side
    modport slave (
        input  Op, Funct, IsMul, MulDone,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, MulStart, MulErr, State
    );

    // Controller / environment side
    modport master (
        output Op, Funct, IsMul, MulDone,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, MulStart, MulErr, State
    );
endinterface

// File: rtl/multicycle_mainfsm.sv
// Main sequencing FSM of the multicycle ARM core. Steps the shared datapath
// through fetch/decode/execute/memory/writeback and runs a start/done
// handshake with the iterative multiplier, guarded by a watchdog timeout.
module multicycle_mainfsm #(
    parameter int unsigned MUL_TIMEOUT = 32,
    parameter int unsigned CNT_W       = 6
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_mainfsm_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        EXECMUL = 4'd10,
        WAITMUL = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mul_err;
    logic             w_timeout;

    logic             w_irwrite;
    logic             w_nextpc;
    logic             w_adrsrc;
    logic [1:0]       w_alusrca;
    logic [1:0]       w_alusrcb;
    logic [1:0]       w_resultsrc;
    logic             w_aluop;
    logic             w_regw;
    logic             w_memw;
    logic             w_branch;
    logic             w_mulstart;

    // Watchdog expiry: last allowed WAITMUL cycle with no result; completion wins
    assign w_timeout = (r_state == WAITMUL) && !bus.MulDone && (r_cnt == LP_CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Multiplier watchdog counter and registered timeout pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mul_err <= 1'b0;
        end else begin
            r_mul_err <= w_timeout;
            if (r_state == EXECMUL) begin
                r_cnt <= '0;
            end else if ((r_state == WAITMUL) && !bus.MulDone && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next      = FETCH;
        w_irwrite   = 1'b0;
        w_nextpc    = 1'b0;
        w_adrsrc    = 1'b0;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_resultsrc = 2'b00;
        w_aluop     = 1'b0;
        w_regw      = 1'b0;
        w_memw      = 1'b0;
        w_branch    = 1'b0;
        w_mulstart  = 1'b0;
        case (r_state)
            FETCH: begin
                w_next      = DECODE;
                w_irwrite   = 1'b1;
                w_nextpc    = 1'b1;
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            DECODE: begin
                w_alusrca   = 2'b01;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                if (bus.Op == 2'b01) begin
                    w_next = MEMADR;
                end else if (bus.Op == 2'b00) begin
                    if (bus.IsMul) begin
                        w_next = EXECMUL;
                    end else if (bus.Funct[5]) begin
                        w_next = EXECI;
                    end else begin
                        w_next = EXECR;
                    end
                end else if (bus.Op == 2'b10) begin
                    w_next = BRANCH;
                end else begin
                    w_next = FETCH;
                end
            end
            MEMADR: begin
                w_alusrcb = 2'b01;
                w_next    = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                w_adrsrc = 1'b1;
                w_next   = MEMWB;
            end
            MEMWB: begin
                w_resultsrc = 2'b01;
                w_regw      = 1'b1;
                w_next      = FETCH;
            end
            MEMWR: begin
                w_adrsrc = 1'b1;
                w_memw   = 1'b1;
                w_next   = FETCH;
            end
            EXECR: begin
                w_aluop = 1'b1;
                w_next  = ALUWB;
            end
            EXECI: begin
                w_alusrcb = 2'b01;
                w_aluop   = 1'b1;
                w_next    = ALUWB;
            end
            ALUWB: begin
                w_regw = 1'b1;
                w_next = FETCH;
            end
            BRANCH: begin
                w_alusrca   = 2'b10;
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_branch    = 1'b1;
                w_next      = FETCH;
            end
            EXECMUL: begin
                w_mulstart = 1'b1;
                w_next     = WAITMUL;
            end
            WAITMUL: begin
                if (bus.MulDone) begin
                    w_next = ALUWB;
                end else if (w_timeout) begin
                    w_next = FETCH;
                end else begin
                    w_next = WAITMUL;
                end
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Strobes are gated by reset so none escapes while the async reset is high
    assign bus.IRWrite   = w_irwrite  & ~reset;
    assign bus.NextPC    = w_nextpc   & ~reset;
    assign bus.RegW      = w_regw     & ~reset;
    assign bus.MemW      = w_memw     & ~reset;
    assign bus.Branch    = w_branch   & ~reset;
    assign bus.MulStart  = w_mulstart & ~reset;
    assign bus.AdrSrc    = w_adrsrc;
    assign bus.ALUSrcA   = w_alusrca;
    assign bus.ALUSrcB   = w_alusrcb;
    assign bus.ResultSrc = w_resultsrc;
    assign bus.ALUOp     = w_aluop;
    assign bus.MulErr    = r_mul_err;
    assign bus.State     = r_state;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Scoreboard bench for multicycle_mainfsm: the driver expands each
// instruction into its expected per-cycle state/output list, and a monitor
// on the falling edge pops and compares.
module tb_multicycle_mainfsm;

    localparam int unsigned T = 4;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] outs;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   pending_err = 1'b0;
    exp_t q[$];

    multicycle_mainfsm_if bus();

    multicycle_mainfsm #(.MUL_TIMEOUT(T), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output vector: {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,MulStart,MulErr}
    function automatic logic [14:0] spec_outs(input int st, input bit err);
        logic ir, npc, adr, aop, rw, mw, br, ms;
        logic [1:0] sa, sb, rs;
        {ir, npc, adr, aop, rw, mw, br, ms} = '0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (st)
            0:  begin ir = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            2:  sb = 2'b01;
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  aop = 1;
            7:  begin sb = 2'b01; aop = 1; end
            8:  rw = 1;
            9:  begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1; end
            10: ms = 1;
            default: ;
        endcase
        return {ir, npc, adr, sa, sb, rs, aop, rw, mw, br, ms, err};
    endfunction

    function automatic logic [14:0] dut_outs();
        return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ResultSrc, bus.ALUOp, bus.RegW, bus.MemW, bus.Branch,
                bus.MulStart, bus.MulErr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per cycle while the driver is issuing
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("state(exp %0d)", e.st), 32'(bus.State), 32'(e.st));
                check($sformatf("outs(state %0d)", e.st), 32'(dut_outs()), 32'(e.outs));
            end
        end
    end

    // Expected state walk for one instruction; d = WAITMUL cycle (1-based) where MulDone rises
    task automatic build(input logic [1:0] op, input logic [5:0] funct, input bit ismul,
                         input int d, output int sts[$], output bit tmo);
        sts = {0, 1};
        tmo = 1'b0;
        if (op == 2'b01) begin
            sts.push_back(2);
            if (funct[0]) begin sts.push_back(3); sts.push_back(4); end
            else          sts.push_back(5);
        end else if (op == 2'b00) begin
            if (ismul) begin
                sts.push_back(10);
                for (int w = 1; w <= int'(T); w++) begin
                    sts.push_back(11);
                    if (w == d) begin sts.push_back(8); break; end
                    if (w == int'(T)) tmo = 1'b1;
                end
            end else begin
                sts.push_back(funct[5] ? 7 : 6);
                sts.push_back(8);
            end
        end else if (op == 2'b10) begin
            sts.push_back(9);
        end
    endtask

    // Drive one instruction starting in its FETCH cycle (called at posedge+1)
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input bit ismul, input int d);
        int sts[$];
        bit tmo;
        int w = 0;
        exp_t e;
        build(op, funct, ismul, d, sts, tmo);
        bus.Op = op; bus.Funct = funct; bus.IsMul = ismul;
        foreach (sts[i]) begin
            if (sts[i] == 11) begin
                w++;
                bus.MulDone = (w == d);
            end else begin
                bus.MulDone = 1'($urandom_range(0, 1));
            end
            e.st   = 4'(sts[i]);
            e.outs = spec_outs(sts[i], (i == 0) && pending_err);
            q.push_back(e);
            @(posedge clk); #1;
        end
        pending_err = tmo;
    endtask

    task automatic reset_during_memwr();
        int sts[$] = {0, 1, 2};
        exp_t e;
        bus.Op = 2'b01; bus.Funct = 6'b011000; bus.IsMul = 1'b0; bus.MulDone = 1'b0;
        foreach (sts[i]) begin
            e.st = 4'(sts[i]);
            e.outs = spec_outs(sts[i], (i == 0) && pending_err);
            q.push_back(e);
            @(posedge clk); #1;
        end
        #1;
        check("memwr_state", 32'(bus.State), 32'd5);
        check("memwr_memw", 32'(bus.MemW), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_state", 32'(bus.State), 32'd0);
        check("rst_memw", 32'(bus.MemW), 32'd0);
        check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        check("rst_nextpc", 32'(bus.NextPC), 32'd0);
        pending_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.Op = 2'b00; bus.Funct = '0; bus.IsMul = 1'b0; bus.MulDone = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset_state", 32'(bus.State), 32'd0);
            check("reset_irwrite", 32'(bus.IRWrite), 32'd0);
            check("reset_nextpc", 32'(bus.NextPC), 32'd0);
            check("reset_mulerr", 32'(bus.MulErr), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(2'b01, 6'b011001, 1'b0, 0);   // LDR
        run_instr(2'b01, 6'b011000, 1'b0, 0);   // STR
        run_instr(2'b10, 6'b000000, 1'b0, 0);   // B
        run_instr(2'b00, 6'b000000, 1'b1, 3);   // MUL, done on 3rd wait cycle
        run_instr(2'b00, 6'b100000, 1'b1, 99);  // MUL timeout
        run_instr(2'b00, 6'b000001, 1'b0, 0);   // EXECR, FETCH carries MulErr
        run_instr(2'b00, 6'b000000, 1'b1, int'(T)); // done on last allowed cycle
        run_instr(2'b11, 6'b111111, 1'b1, 0);   // undefined
        run_instr(2'b00, 6'b100000, 1'b0, 0);   // EXECI
        run_instr(2'b01, 6'b000001, 1'b1, 0);   // Op=01 beats IsMul

        reset_during_memwr();

        for (int n = 0; n < 300; n++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, T + 2)));
        end
        run_instr(2'b10, 6'b000000, 1'b0, 0);

        @(posedge clk); #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_mainfsm.md
Name: multicycle_mainfsm

Overview:
- Main sequencing FSM for the multicycle ARM core. It replaces single-cycle operation by stepping the shared datapath (one memory, one ALU) through fetch, decode, execute, memory and writeback phases.
- Adds a start/done handshake to an iterative multiplier, with a watchdog timeout.
- Sits inside the controller. Condition-check logic gates RegW/MemW/Branch downstream; that logic is outside this block.

Parameters:
- MUL_TIMEOUT, 32, max cycles spent in WAITMUL before abort (≥2).
- CNT_W, 6, width of timeout counter; must satisfy 2^CNT_W > MUL_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]; [5]=I, [0]=L/S
- IsMul  input  1  decoder flag: data-processing instruction is MUL
- MulDone  input  1  multiplier result valid (level)
- IRWrite  output  1  latch instruction register
- NextPC  output  1  PC update strobe
- AdrSrc  output  1  0=PC, 1=ALU result as memory address
- ALUSrcA  output  2  00=RegA, 01=PC, 10=ALUOut
- ALUSrcB  output  2  00=RegB, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUOp  output  1  1=decode ALU op from Funct, 0=add
- RegW  output  1  register write (unconditioned)
- MemW  output  1  memory write (unconditioned)
- Branch  output  1  branch strobe (unconditioned)
- MulStart  output  1  one-cycle multiplier start pulse
- MulErr  output  1  one-cycle pulse on multiply timeout
- State  output  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, EXECMUL=10, WAITMUL=11. Codes 12–15 go to FETCH on the next edge and drive all-zero outputs.
- State register and timeout counter reset asynchronously: state=FETCH, counter=0, MulErr register=0.
- While reset=1, IRWrite, NextPC, RegW, MemW, Branch and MulStart are forced to 0. Mux selects are free to show FETCH values.
- Outputs are Moore, decoded combinationally from State, except MulErr, which is registered. Any signal not listed for a state is 0.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
  - EXECMUL: ALUSrcA=00, ALUSrcB=00, MulStart=1.
  - WAITMUL: all zero.
- Transitions:
  - FETCH→DECODE.
  - DECODE, priority order: Op=01→MEMADR; Op=00 & IsMul→EXECMUL; Op=00 & Funct[5]=1→EXECI; Op=00→EXECR; Op=10→BRANCH; Op=11→FETCH (undefined, no side effects).
  - MEMADR: Funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
  - EXECMUL→WAITMUL; counter cleared to 0 on this edge.
  - WAITMUL: MulDone=1→ALUWB. Else if counter==MUL_TIMEOUT-1→FETCH and MulErr=1 for the next cycle. Else stay and increment the counter.
  - MulDone sampled high in the same cycle as the timeout condition: completion wins, no MulErr.
- MulDone outside WAITMUL is ignored.
- Cycle counts per instruction class (DECODE samples Op/Funct/IsMul only in the DECODE cycle):
  - LDR: 5 cycles. STR: 4. Data-processing: 4. B: 3.
  - MUL: 4+k cycles, where k = WAITMUL cycles and k ≥ 1.
- Reset mid-instruction: returns to FETCH immediately; no strobe may be seen after reset rises.

Test Plan:
- Reset high for 2 cycles, then release → State=0, IRWrite=1 and NextPC=1 in the first post-reset cycle; both 0 while reset=1.
- Op=01, Funct=6'b011001 (LDR imm) → State sequence 0,1,2,3,4,0; RegW=1 only in state 4 with ResultSrc=01; MemW never 1.
- Op=01, Funct[0]=0 (STR) → sequence 0,1,2,5,0; MemW=1 for exactly one cycle with AdrSrc=1. Op=10 → 0,1,9,0 with Branch=1, ALUSrcA=10.
- Op=00, IsMul=1, MulDone raised 3 cycles after MulStart → MulStart is a single-cycle pulse; 3 cycles in WAITMUL; ALUWB asserts RegW=1; MulErr stays 0.
- MUL with MulDone held 0, MUL_TIMEOUT=4 → exactly 4 WAITMUL cycles, then FETCH with MulErr=1 for one cycle. Repeat with MulDone=1 on the 4th WAITMUL cycle → ALUWB, no MulErr.
- Assert reset while State=MEMWR, asynchronously mid-cycle → MemW drops in the same cycle, State=0; Op=11 in DECODE → returns to FETCH with no RegW/MemW/Branch.
